// File: rtl/div_seq.sv
// div_seq -- multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
//
// Restoring shift-subtract divider producing one quotient bit per clock.
// Accepts a one-cycle start in IDLE and reports completion with a single-cycle
// ready pulse. A flush returns to IDLE without a ready pulse.
//
// Optional feature macro: DIV_SEQ_SKIP_EN
//   When defined, an operation whose dividend magnitude is below the divisor
//   magnitude skips the iteration loop (quotient 0, remainder = dividend).
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-low reset
//   start_i      request, accepted only in IDLE with op_i[2] = 1 and no flush
//   op_i         funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i   rs1 value, sampled at acceptance
//   divisor_i    rs2 value, sampled at acceptance
//   reg_waddr_i  destination register, sampled at acceptance
//   flush_i      aborts the operation in flight
//   result_o     quotient or remainder, valid while ready_o = 1
//   ready_o      single-cycle completion pulse
//   busy_o       high while not IDLE
//   reg_waddr_o  captured destination register, valid with ready_o
module div_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CALC,
        S_END
    } state_e;

    state_e          state_q,  state_d;
    logic [1:0]      op_q,     op_d;      // [1] = remainder, [0] = unsigned
    logic [XLEN-1:0] dvd_q,    dvd_d;     // dividend; quotient bits shift in from the LSB
    logic [XLEN-1:0] dvs_q,    dvs_d;     // divisor (magnitude after START)
    logic [XLEN-1:0] rem_q,    rem_d;     // partial remainder, always < divisor
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            qneg_q,   qneg_d;
    logic            rneg_q,   rneg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q,  ready_d;
    logic            busy_q,   busy_d;
    logic [4:0]      waddr_q,  waddr_d;

    logic            is_signed;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic [XLEN:0]   trial;     // P' = {P, next dividend MSB}, one bit wider than P
    logic            take;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        is_signed = ~op_q[0];
        dvd_mag   = (is_signed && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
        dvs_mag   = (is_signed && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
        trial     = {rem_q, dvd_q[XLEN-1]};
        take      = (trial >= {1'b0, dvs_q});
        // The true difference is below 2^XLEN, so the truncated subtraction is exact.
        diff      = trial[XLEN-1:0] - dvs_q;
        quo_fix   = qneg_q ? -dvd_q : dvd_q;
        rem_fix   = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = 1'b0;
        waddr_d  = waddr_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && op_i[2] && !flush_i) begin
                    op_d    = op_i[1:0];
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    waddr_d = reg_waddr_i;
                    state_d = S_START;
                end
            end
            S_START: begin
                qneg_d = is_signed & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                rneg_d = is_signed & dvd_q[XLEN-1];
                dvs_d  = dvs_mag;
                cnt_d  = '0;
                rem_d  = '0;
                if (dvs_q == '0) begin
                    // Quotient must read all ones regardless of dividend sign.
                    dvd_d   = '1;
                    qneg_d  = 1'b0;
                    rem_d   = dvd_mag;
                    state_d = S_END;
                end
`ifdef DIV_SEQ_SKIP_EN
                else if (dvd_mag < dvs_mag) begin
                    dvd_d   = '0;
                    rem_d   = dvd_mag;
                    state_d = S_END;
                end
`endif
                else begin
                    dvd_d   = dvd_mag;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = take ? diff : trial[XLEN-1:0];
                dvd_d = {dvd_q[XLEN-2:0], take};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                ready_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush beats completion: no pulse and the previous result is held.
        if (flush_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            waddr_q  <= waddr_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign reg_waddr_o = waddr_q;

endmodule
